// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state, grant-index and error-data definitions for mem_arbiter2
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  typedef logic gnt_idx_t;

  localparam int ARB_MAX_DATA_W = 64;
  localparam logic [ARB_MAX_DATA_W-1:0] ARB_RDATA_ERR = '1;

endpackage

// File: rtl/mem_arbiter2_rr_pick2.sv
// rtl/mem_arbiter2_rr_pick2.sv - combinational two-way round-robin picker
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_last,
  output logic       o_any,
  output logic       o_grant
);

  gnt_idx_t w_grant;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    w_grant = 1'b0;
    if (&i_valid) begin
      w_grant = ~i_last;
    end else begin
      w_grant = i_valid[1];
    end
  end

  assign o_any   = |i_valid;
  assign o_grant = w_grant;

endmodule

// File: rtl/mem_arbiter2.sv
// rtl/mem_arbiter2.sv - two-requester round-robin arbiter in front of a single memory slave
// Optional BUSY timeout abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter2
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 2,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_m0_valid,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic              i_m0_wen,
  input  logic [DATA_W-1:0] i_m0_wdata,
  output logic              o_m0_ready,
  output logic [DATA_W-1:0] o_m0_rdata,
  input  logic              i_m1_valid,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic              i_m1_wen,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic              o_m1_ready,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic              o_s_valid,
  output logic [ADDR_W-1:0] o_s_addr,
  output logic              o_s_wen,
  output logic [DATA_W-1:0] o_s_wdata,
  input  logic              i_s_ready,
  input  logic [DATA_W-1:0] i_s_rdata,
  output logic              o_timeout
);

  arb_state_t        r_state;
  gnt_idx_t          r_last;
  gnt_idx_t          r_gnt;
  logic              w_any;
  gnt_idx_t          w_gnt;
  logic              w_expire;
  logic [DATA_W-1:0] w_rsp_data;

  rr_pick2 u_pick (
    .i_valid ({i_m1_valid, i_m0_valid}),
    .i_last  (r_last),
    .o_any   (w_any),
    .o_grant (w_gnt)
  );

  // A slave ready always beats an expiring timeout in the same cycle.
  assign w_rsp_data = i_s_ready ? i_s_rdata : ARB_RDATA_ERR[DATA_W-1:0];

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  assign w_expire = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= (r_state == ST_BUSY) && !i_s_ready && w_expire;
      if (r_state != ST_BUSY) begin
        r_cnt <= '0;
      end else if (!i_s_ready) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_timeout = r_timeout;
`else
  assign w_expire  = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_last     <= 1'b1;
      r_gnt      <= 1'b0;
      o_s_valid  <= 1'b0;
      o_s_addr   <= '0;
      o_s_wen    <= 1'b0;
      o_s_wdata  <= '0;
      o_m0_ready <= 1'b0;
      o_m1_ready <= 1'b0;
      o_m0_rdata <= '0;
      o_m1_rdata <= '0;
    end else begin
      o_m0_ready <= 1'b0;
      o_m1_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state   <= ST_BUSY;
            r_gnt     <= w_gnt;
            r_last    <= w_gnt;
            o_s_valid <= 1'b1;
            o_s_addr  <= w_gnt ? i_m1_addr  : i_m0_addr;
            o_s_wen   <= w_gnt ? i_m1_wen   : i_m0_wen;
            o_s_wdata <= w_gnt ? i_m1_wdata : i_m0_wdata;
          end
        end
        ST_BUSY: begin
          if (i_s_ready || w_expire) begin
            r_state   <= ST_RESP;
            o_s_valid <= 1'b0;
            if (r_gnt) begin
              o_m1_ready <= 1'b1;
              o_m1_rdata <= w_rsp_data;
            end else begin
              o_m0_ready <= 1'b1;
              o_m0_rdata <= w_rsp_data;
            end
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter2.sv
// tb/tb_mem_arbiter2.sv - scoreboard bench for mem_arbiter2 with a transaction-level reference model
module tb_mem_arbiter2;

  localparam int AW = 2;
  localparam int DW = 32;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TB_TO = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TB_TO = 15;
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    m_valid = '0;
  logic [1:0]    m_wen = '0;
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdata [2];
  logic [1:0]    m_ready;
  logic [DW-1:0] m_rdata [2];
  logic          o_s_valid, o_s_wen, o_timeout;
  logic [AW-1:0] o_s_addr;
  logic [DW-1:0] o_s_wdata;
  logic          i_s_ready = 1'b0;
  logic [DW-1:0] i_s_rdata = '0;

  always #5 clk = ~clk;

  mem_arbiter2 #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TB_TO)) dut (
    .clk(clk), .rst(rst),
    .i_m0_valid(m_valid[0]), .i_m0_addr(m_addr[0]), .i_m0_wen(m_wen[0]), .i_m0_wdata(m_wdata[0]),
    .o_m0_ready(m_ready[0]), .o_m0_rdata(m_rdata[0]),
    .i_m1_valid(m_valid[1]), .i_m1_addr(m_addr[1]), .i_m1_wen(m_wen[1]), .i_m1_wdata(m_wdata[1]),
    .o_m1_ready(m_ready[1]), .o_m1_rdata(m_rdata[1]),
    .o_s_valid(o_s_valid), .o_s_addr(o_s_addr), .o_s_wen(o_s_wen), .o_s_wdata(o_s_wdata),
    .i_s_ready(i_s_ready), .i_s_rdata(i_s_rdata), .o_timeout(o_timeout)
  );

  int n_checks = 0;
  int n_errs = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Requester inputs as the arbiter saw them at each edge; reset edges present nothing.
  logic [1:0]    snap_v = '0;
  logic [1:0]    snap_wen = '0;
  logic [AW-1:0] snap_addr [2];
  logic [DW-1:0] snap_wdata [2];
  always @(posedge clk) begin
    snap_v     <= rst ? 2'b00 : m_valid;
    snap_wen   <= m_wen;
    snap_addr  <= m_addr;
    snap_wdata <= m_wdata;
  end

  typedef struct {
    logic          idx;
    logic [DW-1:0] rdata;
    logic          to;
    int            due;
  } exp_t;
  exp_t sbq[$];

  int unsigned   wait_lo = 0;
  int unsigned   wait_hi = 0;
  bit            force_rd_en = 1'b0;
  logic [DW-1:0] force_rd = '0;

  // Reference model and slave: one transaction at a time, three-cycle minimum per transaction.
  typedef enum int {M_IDLE, M_BUSY, M_RESP, M_GAP} mphase_t;
  mphase_t       m_ph = M_IDLE;
  logic          m_last = 1'b1;
  logic          m_win;
  logic [AW-1:0] e_addr;
  logic          e_wen;
  logic [DW-1:0] e_wdata;
  int unsigned   m_w;
  int            busy_n;

  always @(negedge clk) begin
    logic [DW-1:0] rd;
    exp_t e;
    if (rst) begin
      m_ph = M_IDLE;
      m_last = 1'b1;
      i_s_ready = 1'b0;
      i_s_rdata = '0;
    end else begin
      case (m_ph)
        M_IDLE: begin
          chk("s_valid_after_idle", o_s_valid, snap_v != 2'b00);
          if (snap_v != 2'b00) begin
            m_win   = (snap_v == 2'b11) ? !m_last : snap_v[1];
            m_last  = m_win;
            e_addr  = snap_addr[m_win];
            e_wen   = snap_wen[m_win];
            e_wdata = snap_wdata[m_win];
            m_w     = $urandom_range(wait_hi, wait_lo);
            busy_n  = 0;
            m_ph    = M_BUSY;
          end
        end
        M_RESP: begin
          chk("s_valid_in_resp", o_s_valid, 0);
          m_ph = M_GAP;
        end
        M_GAP: begin
          chk("s_valid_gap", o_s_valid, 0);
          m_ph = M_IDLE;
        end
        default: ;
      endcase
      if (m_ph == M_BUSY) begin
        busy_n++;
        chk("s_valid_busy", o_s_valid, 1);
        chk("s_addr", o_s_addr, e_addr);
        chk("s_wen", o_s_wen, e_wen);
        chk("s_wdata", o_s_wdata, e_wdata);
        rd = force_rd_en ? force_rd : $urandom;
        i_s_rdata = rd;
        e.idx = m_win;
        e.due = cyc + 1;
        if (busy_n > int'(m_w)) begin
          i_s_ready = 1'b1;
          e.rdata = rd;
          e.to = 1'b0;
          sbq.push_back(e);
          m_ph = M_RESP;
        end else begin
          i_s_ready = 1'b0;
          if (TO_EN && busy_n == TB_TO) begin
            e.rdata = '1;
            e.to = 1'b1;
            sbq.push_back(e);
            m_ph = M_RESP;
          end
        end
      end else begin
        i_s_ready = 1'b0;
      end
    end
  end

  logic [DW-1:0] held [2] = '{default: '0};

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sbq.delete();
      held[0] = '0;
      held[1] = '0;
    end else begin
      n_checks++;
      if (sbq.size() > 0 && sbq[0].due < cyc) begin
        n_errs++;
        $display("FAIL resp_missing: no ready by cycle %0d, required at %0d", cyc, sbq[0].due);
        void'(sbq.pop_front());
      end
      for (int i = 0; i < 2; i++) begin
        if (!m_ready[i]) chk("rdata_hold", m_rdata[i], held[i]);
      end
      chk("timeout_without_ready", o_timeout && (m_ready == 2'b00), 0);
      if (m_ready != 2'b00) begin
        chk("ready_one_hot", m_ready == 2'b11, 0);
        n_checks++;
        if (sbq.size() == 0) begin
          n_errs++;
          $display("FAIL unexpected_ready: ready=%b with nothing outstanding", m_ready);
        end else begin
          e = sbq.pop_front();
          chk("ready_idx", m_ready, e.idx ? 2'b10 : 2'b01);
          chk("resp_rdata", m_rdata[e.idx], e.rdata);
          chk("resp_timeout", o_timeout, e.to);
          chk("resp_cycle", cyc, e.due);
        end
        for (int i = 0; i < 2; i++) begin
          if (m_ready[i]) held[i] = m_rdata[i];
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    m_valid[i] = 1'b1;
    m_addr[i]  = a;
    m_wen[i]   = w;
    m_wdata[i] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_s_valid", o_s_valid, 0);
    chk("rst_s_addr", o_s_addr, 0);
    chk("rst_s_wdata", o_s_wdata, 0);
    chk("rst_ready", m_ready, 0);
    chk("rst_rdata0", m_rdata[0], 0);
    chk("rst_rdata1", m_rdata[1], 0);
    chk("rst_timeout", o_timeout, 0);
    m_valid = '0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    int n_g;
    int order [4];
    int sv;
    int first;
    logic got, to_seen;

    m_addr = '{default: '0};
    m_wdata = '{default: '0};
    #1 rst = 1'b1;
    #1;
    chk("init_s_valid", o_s_valid, 0);
    chk("init_ready", m_ready, 0);
    chk("init_s_wen", o_s_wen, 0);
    @(negedge clk);
    #2 rst = 1'b0;

    // Single read from m0 against a zero-wait slave.
    wait_lo = 0; wait_hi = 0;
    force_rd_en = 1'b1; force_rd = 32'h0000_00A5;
    @(negedge clk);
    set_req(0, 2'd1, 1'b0, 32'h1234_5678);
    @(negedge clk);
    chk("s030_s_valid_n1", o_s_valid, 1);
    chk("s030_s_addr", o_s_addr, 1);
    chk("s030_no_ready_n1", m_ready, 0);
    @(negedge clk);
    chk("s030_ready_n2", m_ready, 2'b01);
    chk("s030_rdata", m_rdata[0], 32'h0000_00A5);
    m_valid[0] = 1'b0;
    @(negedge clk);
    chk("s030_ready_1cyc", m_ready, 0);
    force_rd_en = 1'b0;

    // Both requesters held valid continuously from reset.
    do_reset();
    @(negedge clk);
    set_req(0, 2'd0, 1'b0, $urandom);
    set_req(1, 2'd3, 1'b1, $urandom);
    n_g = 0;
    for (int k = 0; k < 40 && n_g < 4; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (m_ready[i] && n_g < 4) begin
          order[n_g] = i;
          n_g++;
          set_req(i, 2'(i), 1'b0, $urandom);
        end
      end
    end
    m_valid = '0;
    chk("s031_grants", n_g, 4);
    for (int k = 0; k < 4; k++) chk("s031_order", order[k], k % 2);
    repeat (10) @(negedge clk);

    // m1 write whose payload changes after it has been latched.
    wait_lo = 3; wait_hi = 3;
    @(negedge clk);
    set_req(1, 2'd2, 1'b1, 32'h0000_003C);
    sv = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_s_valid) begin
        chk("s032_s_wdata", o_s_wdata, 32'h0000_003C);
        chk("s032_s_addr", o_s_addr, 2);
        m_wdata[1] = 32'h0000_00FF;
        sv++;
      end
      if (m_ready[1]) begin
        m_valid[1] = 1'b0;
        break;
      end
    end
    chk("s032_busy_cycles", sv, 4);
    repeat (3) @(negedge clk);

    // Slave holds ready low for five cycles.
    wait_lo = 5; wait_hi = 5;
    @(negedge clk);
    set_req(0, 2'd3, 1'b0, $urandom);
    sv = 0; got = 1'b0; to_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_s_valid) sv++;
      if (m_ready[0]) begin
        got = 1'b1;
        to_seen = o_timeout;
        m_valid[0] = 1'b0;
        break;
      end
    end
    chk("s033_s_valid_cycles", sv, TO_EN ? TB_TO : 6);
    chk("s033_ready_seen", got, 1);
    chk("s033_timeout", to_seen, TO_EN);
    @(negedge clk);
    chk("s033_timeout_pulse", o_timeout, 0);
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of BUSY.
    wait_lo = 10; wait_hi = 10;
    @(negedge clk);
    set_req(0, 2'd1, 1'b1, 32'hDEAD_BEEF);
    repeat (3) @(negedge clk);
    chk("s034_busy_before_rst", o_s_valid, 1);
    do_reset();
    wait_lo = 0; wait_hi = 0;
    repeat (4) begin
      @(negedge clk);
      chk("s034_no_ready_after_rst", m_ready, 0);
    end
    set_req(0, 2'd2, 1'b0, $urandom);
    set_req(1, 2'd1, 1'b0, $urandom);
    first = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_ready != 2'b00) begin
        first = m_ready[1] ? 1 : 0;
        break;
      end
    end
    chk("s034_first_tie", first, 0);
    m_valid = '0;
    repeat (8) @(negedge clk);

    // Random traffic: holds, drops, payload churn, variable slave wait.
    wait_lo = 0; wait_hi = 5;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (m_valid[i] && m_ready[i]) begin
          if ($urandom_range(1, 0) == 1) set_req(i, 2'($urandom), 1'($urandom), $urandom);
          else m_valid[i] = 1'b0;
        end else if (!m_valid[i]) begin
          if ($urandom_range(3, 0) == 0) set_req(i, 2'($urandom), 1'($urandom), $urandom);
        end else if ($urandom_range(15, 0) == 0) begin
          m_valid[i] = 1'b0;
        end else if ($urandom_range(7, 0) == 0) begin
          m_wdata[i] = $urandom;
        end
      end
    end
    m_valid = '0;
    repeat (20) @(negedge clk);
    chk("drain_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
